// File: rtl/seq_fixed_point_mul.sv
// Iterative shift-add signed fixed-point multiplier: one multiplier bit per cycle,
// sign-magnitude datapath, Q-format conversion with optional rounding and saturation.
module seq_fixed_point_mul #(
  parameter int unsigned WIIA  = 8,
  parameter int unsigned WIFA  = 8,
  parameter int unsigned WIIB  = 8,
  parameter int unsigned WIFB  = 8,
  parameter int unsigned WOI   = 8,
  parameter int unsigned WOF   = 8,
  parameter int unsigned ROOF  = 1,
  parameter int unsigned ROUND = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIIA+WIFA-1:0]   ina,
  input  logic [WIIB+WIFB-1:0]   inb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WOI+WOF-1:0]     out,
  output logic                   upflow,
  output logic                   downflow
);

  localparam int unsigned WA  = WIIA + WIFA;
  localparam int unsigned WB  = WIIB + WIFB;
  localparam int unsigned W   = WOI + WOF;
  localparam int unsigned WP  = WA + WB;
  localparam int unsigned WFP = WIFA + WIFB;
  localparam int unsigned SHR = (WFP > WOF) ? (WFP - WOF) : 0;
  localparam int unsigned SHL = (WOF > WFP) ? (WOF - WFP) : 0;
  localparam int unsigned MW0 = WP + 1 + SHL;
  localparam int unsigned MW  = (MW0 > W + 1) ? MW0 : (W + 1);
  localparam int unsigned CW  = (WB > 1) ? $clog2(WB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [MW-1:0] POS_MAX = {{(MW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [MW-1:0] NEG_MAX = {{(MW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  SAT_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WA-1:0] ua_q, ua_d;
  logic [WB-1:0] ub_q, ub_d;
  logic          sign_q, sign_d;
  logic [WP-1:0] acc_q, acc_d;
  logic [W-1:0]  out_q, out_d;
  logic          up_q, up_d;
  logic          dn_q, dn_d;
  logic          ov_q, ov_d;

  logic [MW-1:0] mag_c, m_c;
  logic [W-1:0]  sres_c;
  logic          rnd_c, up_c, dn_c;

  // Rounding picks up the highest dropped fraction bit of the magnitude.
  if (ROUND != 0 && SHR > 0) begin : g_rnd
    assign rnd_c = acc_q[SHR-1];
  end else begin : g_nrnd
    assign rnd_c = 1'b0;
  end

  assign mag_c  = (MW'(acc_q) >> SHR) << SHL;
  assign m_c    = mag_c + MW'(rnd_c);
  assign up_c   = !sign_q && (m_c > POS_MAX);
  assign dn_c   = sign_q && (m_c > NEG_MAX);
  assign sres_c = sign_q ? (~m_c[W-1:0] + W'(1)) : m_c[W-1:0];

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = ov_q;
  assign out       = out_q;
  assign upflow    = up_q;
  assign downflow  = dn_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ua_d    = ua_q;
    ub_d    = ub_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    out_d   = out_q;
    up_d    = up_q;
    dn_d    = dn_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ua_d    = ina[WA-1] ? (~ina + WA'(1)) : ina;
          ub_d    = inb[WB-1] ? (~inb + WB'(1)) : inb;
          sign_d  = ina[WA-1] ^ inb[WB-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (ub_q[cnt_q]) begin
          acc_d = acc_q + (WP'(ua_q) << cnt_q);
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WB - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        up_d = up_c;
        dn_d = dn_c;
        if (ROOF != 0 && up_c) begin
          out_d = SAT_POS;
        end else if (ROOF != 0 && dn_c) begin
          out_d = SAT_NEG;
        end else begin
          out_d = sres_c;
        end
        ov_d    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ua_q    <= '0;
      ub_q    <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_seq_fixed_point_mul.sv
// Scoreboard bench for seq_fixed_point_mul: default, ROUND=0 and ROOF=0 instances
// driven in lockstep, results compared against a signed-arithmetic reference.
module tb_seq_fixed_point_mul;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] ina, inb;
  logic        ir [3];
  logic        ov [3];
  logic [15:0] o  [3];
  logic        up [3];
  logic        dn [3];

  int checks = 0;
  int failures = 0;
  logic [17:0] q0[$], q1[$], q2[$];
  logic [17:0] obs [3];
  logic [17:0] expv [3];
  time last_accept_t;

  seq_fixed_point_mul u0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[0]), .ina(ina), .inb(inb),
    .out_valid(ov[0]), .out_ready(out_ready), .out(o[0]), .upflow(up[0]), .downflow(dn[0]));
  seq_fixed_point_mul #(.ROUND(0)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[1]), .ina(ina), .inb(inb),
    .out_valid(ov[1]), .out_ready(out_ready), .out(o[1]), .upflow(up[1]), .downflow(dn[1]));
  seq_fixed_point_mul #(.ROOF(0)) u2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir[2]), .ina(ina), .inb(inb),
    .out_valid(ov[2]), .out_ready(out_ready), .out(o[2]), .upflow(up[2]), .downflow(dn[2]));

  always #5 clk = ~clk;

  // Reference: exact signed product, then Q16.16 -> Q8.8 on the magnitude.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input bit rnd, input bit roof);
    logic signed [31:0] p;
    logic [31:0] mag;
    logic [32:0] m, t;
    logic s, u, d;
    logic [15:0] r;
    p   = $signed(a) * $signed(b);
    mag = p[31] ? 32'(-p) : 32'(p);
    m   = 33'(mag >> 8) + 33'(rnd & mag[7]);
    s   = a[15] ^ b[15];
    u   = !s && (m > 33'd32767);
    d   = s && (m > 33'd32768);
    t   = s ? (33'd0 - m) : m;
    if (roof && u)      r = 16'h7FFF;
    else if (roof && d) r = 16'h8000;
    else                r = t[15:0];
    return {u, d, r};
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit push);
    int n = 0;
    while (!ir[0] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ir[0]) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%b required=1", ir[0]);
    end
    ina = a; inb = b; in_valid = 1'b1;
    @(posedge clk);
    last_accept_t = $time;
    #1 in_valid = 1'b0;
    if (push) begin
      q0.push_back(model(a, b, 1'b1, 1'b1));
      q1.push_back(model(a, b, 1'b0, 1'b1));
      q2.push_back(model(a, b, 1'b1, 1'b0));
    end
  endtask

  task automatic collect(output int lat);
    lat = 0;
    while (!ov[0] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!ov[0]) begin
      checks++; failures++;
      $display("FAIL result_timeout out_valid=%b required=1", ov[0]);
    end
    for (int k = 0; k < 3; k++) obs[k] = {up[k], dn[k], o[k]};
    expv[0] = (q0.size() > 0) ? q0.pop_front() : 18'h3FFFF;
    expv[1] = (q1.size() > 0) ? q1.pop_front() : 18'h3FFFF;
    expv[2] = (q2.size() > 0) ? q2.pop_front() : 18'h3FFFF;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ina = '0; inb = '0;
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b1) begin
        failures++; $display("FAIL reset_in_ready[%0d] got=%b want=1", k, ir[k]);
      end
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ov[k], up[k], dn[k], o[k]} !== 19'h0) begin
        failures++;
        $display("FAIL reset_outputs[%0d] got=%h want=0", k, {ov[k], up[k], dn[k], o[k]});
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    send(16'h0180, 16'h0240, 1'b1);
    collect(lat);
    checks++;
    if (lat != 17) begin
      failures++; $display("FAIL basic_latency got=%0d want=17", lat);
    end
    checks++;
    if (obs[0] !== 18'h00360) begin
      failures++; $display("FAIL basic_value got=%h want=00360", obs[0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin
        failures++; $display("FAIL basic[%0d] got=%h want=%h", k, obs[k], expv[k]);
      end
    end
    release_out();
  endtask

  task automatic test_vectors(input string name, input int which);
    int lat;
    logic [15:0] a, b;
    for (int i = 0; i < 3; i++) begin
      case (which * 3 + i)
        0: begin a = 16'hFE80; b = 16'h0240; end
        1: begin a = 16'hFE80; b = 16'hFDC0; end
        2: begin a = 16'h0000; b = 16'hFF00; end
        3: begin a = 16'h0001; b = 16'h0080; end
        4: begin a = 16'h0001; b = 16'h0040; end
        5: begin a = 16'hFFFF; b = 16'h0080; end
        6: begin a = 16'h6400; b = 16'h0200; end
        7: begin a = 16'h9C00; b = 16'h0200; end
        8: begin a = 16'h0100; b = 16'h7FFF; end
        9:  begin a = 16'h8000; b = 16'h0100; end
        10: begin a = 16'h8000; b = 16'hFF00; end
        default: begin a = 16'h8000; b = 16'h8000; end
      endcase
      send(a, b, 1'b1);
      collect(lat);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          failures++;
          $display("FAIL %s[%0d] a=%h b=%h got=%h want=%h", name, k, a, b, obs[k], expv[k]);
        end
      end
      release_out();
    end
  endtask

  task automatic test_hold();
    int lat;
    int seen = 0;
    send(16'h0180, 16'h0240, 1'b1);
    collect(lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0]; ina = 16'h7777; inb = 16'h1234;
      @(posedge clk); #1;
      checks++;
      if ({ov[0], ir[0], up[0], dn[0], o[0]} !== {1'b1, 1'b0, expv[0]}) begin
        failures++;
        $display("FAIL hold[%0d] got=%h want=%h", c, {ov[0], ir[0], up[0], dn[0], o[0]},
                 {1'b1, 1'b0, expv[0]});
      end
    end
    in_valid = 1'b0;
    release_out();
    for (int c = 0; c < 25; c++) begin
      if (ov[0]) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || ir[0] !== 1'b1) begin
      failures++; $display("FAIL hold_ignored spurious=%0d in_ready=%b want 0/1", seen, ir[0]);
    end
  endtask

  task automatic test_abort();
    int lat;
    int seen = 0;
    send(16'h6400, 16'h0200, 1'b0);
    repeat (7) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ov[k], ir[k], up[k], dn[k], o[k]} !== {1'b0, 1'b1, 18'h0}) begin
        failures++;
        $display("FAIL abort[%0d] got=%h want=%h", k, {ov[k], ir[k], up[k], dn[k], o[k]},
                 {1'b0, 1'b1, 18'h0});
      end
    end
    @(posedge clk); #1 rstn = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (ov[0]) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL abort_no_result spurious=%0d want=0", seen);
    end
    send(16'h0180, 16'h0240, 1'b1);
    collect(lat);
    checks++;
    if (obs[0] !== 18'h00360 || obs[0] !== expv[0]) begin
      failures++; $display("FAIL abort_recover got=%h want=00360", obs[0]);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    time prev_t;
    logic [15:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (i == 0) begin a = 16'h8000; b = 16'h8000; end
      prev_t = last_accept_t;
      send(a, b, 1'b1);
      if (i > 0) begin
        checks++;
        if (last_accept_t - prev_t != 190) begin
          failures++; $display("FAIL b2b_period got=%0t want=190", last_accept_t - prev_t);
        end
      end
      collect(lat);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          failures++;
          $display("FAIL b2b[%0d] a=%h b=%h got=%h want=%h", k, a, b, obs[k], expv[k]);
        end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (q0.size() != 0 || ov[0] !== 1'b0) begin
      failures++; $display("FAIL b2b_drain pending=%0d out_valid=%b want 0/0", q0.size(), ov[0]);
    end
  endtask

  initial begin
    last_accept_t = 0;
    test_reset();
    test_basic();
    test_vectors("sign", 0);
    test_vectors("round", 1);
    test_vectors("overflow", 2);
    test_vectors("extreme", 3);
    test_hold();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
